// File: rtl/logicnet_layer_skid_reg.sv
// Registered valid/ready boundary between two LogicNet layers: a two-entry skid
// buffer (MAIN visible, SKID hidden) with sample tag and saturating stall counter.
module logicnet_layer_skid_reg #(
    parameter int unsigned WIDTH = 256,
    parameter int unsigned TAG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    input  logic [TAG_W-1:0] s_tag,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [TAG_W-1:0] m_tag,
    output logic [1:0]       occupancy,
    output logic [15:0]      stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t             state_reg;
    state_t             state_next;
    logic               s_ready_reg;
    logic               m_valid_reg;
    logic [WIDTH-1:0]   main_data_reg;
    logic [TAG_W-1:0]   main_tag_reg;
    logic [WIDTH-1:0]   skid_data_reg;
    logic [TAG_W-1:0]   skid_tag_reg;
    logic [15:0]        stall_reg;

    logic in_fire;
    logic out_fire;
    logic load_main_in;
    logic load_main_skid;
    logic load_skid_in;

    assign in_fire  = s_valid & s_ready_reg;
    assign out_fire = m_valid_reg & m_ready;

    always_comb begin
        state_next     = state_reg;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid_in   = 1'b0;
        case (state_reg)
            EMPTY: begin
                if (in_fire) begin
                    load_main_in = 1'b1;
                    state_next   = ONE;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    load_main_in = 1'b1;
                end else if (in_fire) begin
                    load_skid_in = 1'b1;
                    state_next   = FULL;
                end else if (out_fire) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                // s_ready is low here, so only the drain side can move.
                if (out_fire) begin
                    load_main_skid = 1'b1;
                    state_next     = ONE;
                end
            end
            default: state_next = EMPTY;
        endcase
        // Flush wins over any transfer presented in the same cycle.
        if (flush) begin
            state_next     = EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid_in   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= EMPTY;
            s_ready_reg   <= 1'b0;
            m_valid_reg   <= 1'b0;
            main_data_reg <= '0;
            main_tag_reg  <= '0;
            skid_data_reg <= '0;
            skid_tag_reg  <= '0;
            stall_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            s_ready_reg <= (state_next != FULL);
            m_valid_reg <= (state_next != EMPTY);
            if (load_main_in) begin
                main_data_reg <= s_data;
                main_tag_reg  <= s_tag;
            end else if (load_main_skid) begin
                main_data_reg <= skid_data_reg;
                main_tag_reg  <= skid_tag_reg;
            end
            if (load_skid_in) begin
                skid_data_reg <= s_data;
                skid_tag_reg  <= s_tag;
            end
            if (m_valid_reg && !m_ready && (stall_reg != 16'hFFFF)) begin
                stall_reg <= stall_reg + 16'd1;
            end
        end
    end

    assign s_ready   = s_ready_reg;
    assign m_valid   = m_valid_reg;
    assign m_data    = main_data_reg;
    assign m_tag     = main_tag_reg;
    assign occupancy = state_reg;
    assign stall_cnt = stall_reg;

endmodule

// File: tb/tb_logicnet_layer_skid_reg.sv
// Bench for logicnet_layer_skid_reg: queue-based reference model checked on every
// falling edge, plus directed literal checks for reset, backpressure, flush and saturation.
module tb_logicnet_layer_skid_reg;

    localparam int WIDTH = 256;
    localparam int TAG_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_data;
    logic [TAG_W-1:0] s_tag;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic [TAG_W-1:0] m_tag;
    logic [1:0]       occupancy;
    logic [15:0]      stall_cnt;

    logicnet_layer_skid_reg #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_tag(s_tag),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_tag(m_tag),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic [TAG_W-1:0] t;
    } sample_t;

    sample_t     q[$];
    logic        mdl_ready = 1'b0;
    logic [15:0] mdl_stall = '0;
    bit          mdl_init  = 1'b0;
    int          out_count = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic void chk(string name, logic [WIDTH-1:0] act, logic [WIDTH-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endfunction

    // Compare last edge's result, then advance the model with the inputs the
    // next rising edge will sample (inputs only change just after a rising edge).
    always @(negedge clk) begin
        bit vld, inf, outf;
        sample_t s;
        if (mdl_init) begin
            chk("m_valid", {255'd0, m_valid}, {255'd0, q.size() != 0});
            chk("s_ready", {255'd0, s_ready}, {255'd0, mdl_ready});
            chk("occupancy", {254'd0, occupancy}, WIDTH'(q.size()));
            chk("stall_cnt", {240'd0, stall_cnt}, {240'd0, mdl_stall});
            if (occupancy > 2'd2) chk("occ_range", {254'd0, occupancy}, 256'd2);
            if (q.size() != 0) begin
                chk("m_data", m_data, q[0].d);
                chk("m_tag", {248'd0, m_tag}, {248'd0, q[0].t});
            end
        end
        if (rst) begin
            q.delete();
            mdl_ready = 1'b0;
            mdl_stall = '0;
            mdl_init  = 1'b1;
        end else if (mdl_init) begin
            vld  = (q.size() != 0);
            inf  = s_valid && mdl_ready;
            outf = vld && m_ready;
            if (vld && !m_ready && mdl_stall != 16'hFFFF) mdl_stall = mdl_stall + 16'd1;
            if (flush) begin
                q.delete();
                mdl_ready = 1'b1;
            end else begin
                if (outf) begin
                    void'(q.pop_front());
                    out_count++;
                end
                if (inf) begin
                    s.d = s_data;
                    s.t = s_tag;
                    q.push_back(s);
                end
                mdl_ready = (q.size() != 2);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_tag_pattern(input logic [7:0] t);
        s_tag  = t;
        s_data = {(WIDTH/8){t}};
    endtask

    initial begin
        int base;
        logic [7:0] tg;
        rst = 1'b1; flush = 1'b0; s_valid = 1'b1; m_ready = 1'b1;
        set_tag_pattern(8'h11);

        // Reset held 3 cycles with traffic asserted.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_m_valid", {255'd0, m_valid}, 256'd0);
            chk("rst_s_ready", {255'd0, s_ready}, 256'd0);
            chk("rst_stall", {240'd0, stall_cnt}, 256'd0);
            chk("rst_m_data", m_data, 256'd0);
        end
        rst = 1'b0;
        tick();
        chk("bringup_s_ready", {255'd0, s_ready}, 256'd1);
        chk("bringup_m_valid", {255'd0, m_valid}, 256'd0);
        set_tag_pattern(8'hA5);
        tick();
        chk("first_m_valid", {255'd0, m_valid}, 256'd1);
        chk("first_m_tag", {248'd0, m_tag}, 256'hA5);
        chk("first_m_data", m_data, {32{8'hA5}});
        s_valid = 1'b0;
        tick();

        // Streaming: 100 back-to-back samples.
        base = out_count;
        for (int i = 0; i < 100; i++) begin
            s_valid = 1'b1;
            set_tag_pattern(8'(i));
            tick();
        end
        s_valid = 1'b0;
        tick();
        chk("stream_count", WIDTH'(out_count - base), 256'd100);
        chk("stream_stall", {240'd0, stall_cnt}, 256'd0);

        // Backpressure: m_ready low for 5 cycles while streaming.
        tg = 8'd0;
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1; set_tag_pattern(tg); tg++; tick();
        end
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (s_ready) begin set_tag_pattern(tg); tg++; end
            tick();
        end
        chk("bp_occupancy", {254'd0, occupancy}, 256'd2);
        chk("bp_s_ready", {255'd0, s_ready}, 256'd0);
        chk("bp_stall", {240'd0, stall_cnt}, 256'd5);
        m_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (s_ready) begin set_tag_pattern(tg); tg++; end
            tick();
        end
        s_valid = 1'b0;
        repeat (3) tick();

        // Flush collision in FULL.
        m_ready = 1'b0; s_valid = 1'b1;
        set_tag_pattern(8'hE0); tick();
        set_tag_pattern(8'hE1); tick();
        chk("pre_flush_occ", {254'd0, occupancy}, 256'd2);
        flush = 1'b1; m_ready = 1'b1; set_tag_pattern(8'hEE);
        tick();
        flush = 1'b0; s_valid = 1'b0;
        chk("flush_occ", {254'd0, occupancy}, 256'd0);
        chk("flush_m_valid", {255'd0, m_valid}, 256'd0);
        chk("flush_s_ready", {255'd0, s_ready}, 256'd1);
        repeat (3) tick();

        // Random handshake with random payloads.
        for (int c = 0; c < 10000; c++) begin
            s_valid = 1'($urandom_range(0, 1));
            m_ready = 1'($urandom_range(0, 1));
            s_tag   = 8'($urandom);
            for (int w = 0; w < WIDTH / 32; w++) s_data[w*32 +: 32] = $urandom;
            tick();
        end

        // Saturation: one sample held under backpressure.
        s_valid = 1'b1; m_ready = 1'b0; set_tag_pattern(8'h5A);
        tick();
        s_valid = 1'b0;
        repeat (65600) tick();
        chk("sat_stall", {240'd0, stall_cnt}, 256'hFFFF);
        flush = 1'b1; tick(); flush = 1'b0;
        chk("sat_after_flush", {240'd0, stall_cnt}, 256'hFFFF);
        tick();
        rst = 1'b1; tick(); rst = 1'b0;
        chk("sat_after_rst", {240'd0, stall_cnt}, 256'd0);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
